cm_dispatch: RTL and testbench
==============================

Name: cm_dispatch

Overview:
- Single-stream-in, N-stream-out dispatcher; the distribution-side counterpart of the common arbiter.
- Each accepted input beat carries data plus an eligibility mask of sinks. The block selects exactly one eligible sink using the shared t_arb_algo policy.
- The beat is registered and presented to that sink only, held until the sink accepts.
- Used in front of parallel worker instances fed from one producer.

Parameters:
- N_SINK, 4, number of output streams (>= 2)
- DATA_W, 8, payload width
- ALGO, cm_pkg::ARB_MIN, sink selection policy: ARB_MIN = lowest eligible index, ARB_MAX = highest eligible index
- CNT_W, 8, width of the saturating drop counter

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_vld  in  1  input beat valid
- o_rdy  out  1  input ready
- i_data  in  DATA_W  input payload
- i_mask  in  N_SINK  eligible sinks for this beat, bit k = sink k
- o_vld  out  N_SINK  per-sink valid; at most one bit high
- i_rdy  in  N_SINK  per-sink ready
- o_data  out  DATA_W  payload, shared by all sinks
- o_drop  out  1  one-cycle pulse: a beat with all-zero mask was accepted and discarded
- o_drop_cnt  out  CNT_W  saturating count of dropped beats

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_vld=0, o_data=0, o_drop=0, o_drop_cnt=0, internal state EMPTY, sel=0.
- State: two-state holding register, EMPTY and FULL, plus registered sel (one-hot, N_SINK bits) and data.
- Drain condition: drain = FULL & |(sel & i_rdy).
- Input ready: o_rdy = EMPTY | drain. o_rdy never depends on i_vld, and never on i_rdy bits other than the selected sink.
- Accept condition: accept = i_vld & o_rdy.
- Accept with i_mask != 0:
  - Next sel = one-hot of the lowest set bit (ARB_MIN) or highest set bit (ARB_MAX) of i_mask.
  - Data is registered; state goes to FULL.
- Accept with i_mask == 0:
  - Beat is discarded. o_drop=1 in the next cycle.
  - o_drop_cnt increments, saturating at 2^CNT_W-1.
  - State becomes EMPTY if drain occurs that cycle; otherwise it stays unchanged.
- Outputs: o_vld = sel when FULL, else 0. o_data is driven from the register; it holds its last value when EMPTY and is not cleared.
- FULL with no accept: on drain, state goes to EMPTY. Without drain, state, sel and data are held stable; valid is never withdrawn.
- Simultaneous drain and accept: the new beat loads in the same edge with no bubble. o_vld may move to a different sink in the next cycle.
- Latency: 1 cycle from accept to o_vld. Sustained throughput is 1 beat/cycle when the selected sinks are ready.
- Non-selected sinks' i_rdy is ignored.
- Reset asserted mid-transfer: the held beat is lost. All outputs return to reset values immediately (asynchronous).
- Full 0/1 throughput with no skid buffer; the combinational path from i_rdy to o_rdy is accepted by design.

Decomposition:
- cm_pkg: reuse t_arb_algo unchanged.
- cm_pkg: add the t_disp_st enum (DISP_EMPTY, DISP_FULL).
- Sub-module cm_prio_sel (combinational):
  - Parameters N, ALGO. Input req[N]; outputs gnt one-hot and any.
  - Implements the lowest/highest set bit selection.
  - Reusable by the arbiter.

Test Plan (N_SINK=4, DATA_W=8, CNT_W=8):
- Reset check: assert i_rst mid-FULL -> o_vld=0, o_rdy=1, o_drop_cnt=0 asynchronously, before the next clock edge.
- ALGO=ARB_MIN, i_data=0xA5, i_mask=4'b0110, all i_rdy=1 -> next cycle o_vld=4'b0010, o_data=0xA5, drained in one cycle. Same stimulus with ALGO=ARB_MAX -> o_vld=4'b0100.
- Backpressure: beat 0x11 to sink 1 with i_rdy[1]=0 for 5 cycles, i_rdy[0,2,3]=1 -> o_vld=4'b0010 and o_data=0x11 stable for 5 cycles, o_rdy=0. Raise i_rdy[1] -> drain, o_rdy=1 in the same cycle.
- Back-to-back: stream 0x01,0x02,0x03 with masks 4'b0001, 4'b1000, 4'b0100, all ready -> o_vld sequence 0001, 1000, 0100 on consecutive cycles, no bubble.
- Drops: 3 beats with i_mask=0 -> three o_drop pulses, o_drop_cnt=3, no o_vld. Then preload the counter path with 260 drops -> o_drop_cnt saturates at 255.
- Random run: random i_vld, i_mask and i_rdy over 10k cycles, scoreboard checks:
  - every non-drop beat arrives exactly once, in order, at the correct policy sink;
  - o_vld stays one-hot or zero;
  - there is no change while o_vld is high and i_rdy is low.

Source files
------------

// File: rtl/cm_pkg.sv
// cm_pkg: shared types for the common arbiter / dispatcher family.
//   t_arb_algo : selection policy (lowest or highest eligible index)
//   t_disp_st  : dispatcher holding-register state
package cm_pkg;

   typedef enum logic {
      ARB_MIN,
      ARB_MAX
   } t_arb_algo;

   typedef enum logic {
      DISP_EMPTY,
      DISP_FULL
   } t_disp_st;

endpackage

// File: rtl/cm_prio_sel.sv
// cm_prio_sel: combinational priority selector.
//   i_req [N] : request / eligibility vector
//   o_gnt [N] : one-hot of the lowest (ARB_MIN) or highest (ARB_MAX) set bit of i_req
//   o_any     : at least one bit of i_req is set
module cm_prio_sel
   import cm_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter t_arb_algo   ALGO = ARB_MIN
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt,
   output logic         o_any
);

   always_comb begin
      o_gnt = '0;
      if (ALGO == ARB_MIN) begin
         // Scan downwards so the lowest set bit is the last one written.
         for (int i = int'(N) - 1; i >= 0; i--) begin
            if (i_req[i]) begin
               o_gnt    = '0;
               o_gnt[i] = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < int'(N); i++) begin
            if (i_req[i]) begin
               o_gnt    = '0;
               o_gnt[i] = 1'b1;
            end
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/cm_dispatch.sv
// cm_dispatch: single-stream-in, N-stream-out dispatcher.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_vld/o_rdy/i_data  : input beat handshake and payload
//   i_mask              : sinks eligible for this beat (bit k = sink k)
//   o_vld/i_rdy         : per-sink handshake; at most one o_vld bit high
//   o_data              : payload shared by all sinks
//   o_drop, o_drop_cnt  : pulse and saturating count for beats accepted with an empty mask
module cm_dispatch
   import cm_pkg::*;
#(
   parameter int unsigned N_SINK = 4,
   parameter int unsigned DATA_W = 8,
   parameter t_arb_algo   ALGO   = ARB_MIN,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vld,
   output logic              o_rdy,
   input  logic [DATA_W-1:0] i_data,
   input  logic [N_SINK-1:0] i_mask,
   output logic [N_SINK-1:0] o_vld,
   input  logic [N_SINK-1:0] i_rdy,
   output logic [DATA_W-1:0] o_data,
   output logic              o_drop,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   t_disp_st          r_st;
   logic [N_SINK-1:0] r_sel;
   logic [DATA_W-1:0] r_data;
   logic              r_drop;
   logic [CNT_W-1:0]  r_drop_cnt;

   logic [N_SINK-1:0] w_gnt;
   logic              w_any;
   logic              w_drain;
   logic              w_accept;

   cm_prio_sel #(
      .N    (N_SINK),
      .ALGO (ALGO)
   ) u_prio_sel (
      .i_req (i_mask),
      .o_gnt (w_gnt),
      .o_any (w_any)
   );

   // Only the selected sink's ready matters; this is the accepted i_rdy -> o_rdy path.
   assign w_drain  = (r_st == DISP_FULL) && (|(r_sel & i_rdy));
   assign o_rdy    = (r_st == DISP_EMPTY) || w_drain;
   assign w_accept = i_vld && o_rdy;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_st       <= DISP_EMPTY;
         r_sel      <= '0;
         r_data     <= '0;
         r_drop     <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_drop <= 1'b0;
         if (w_accept && w_any) begin
            // Load over a draining beat in the same edge: no bubble.
            r_st   <= DISP_FULL;
            r_sel  <= w_gnt;
            r_data <= i_data;
         end else begin
            if (w_drain) begin
               r_st <= DISP_EMPTY;
            end
            if (w_accept) begin
               r_drop <= 1'b1;
               if (r_drop_cnt != '1) begin
                  r_drop_cnt <= r_drop_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign o_vld      = (r_st == DISP_FULL) ? r_sel : '0;
   assign o_data     = r_data;
   assign o_drop     = r_drop;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_cm_dispatch.sv
// tb_cm_dispatch: two dispatchers (ARB_MIN and ARB_MAX) share one stimulus stream and are
// checked every cycle against a beat-level model plus directed literal expectations.
module tb_cm_dispatch;
   import cm_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          vld;
   logic [DW-1:0] data;
   logic [N-1:0]  mask;
   logic [N-1:0]  rdy;

   logic          rdy_o  [2];
   logic [N-1:0]  vld_o  [2];
   logic [DW-1:0] data_o [2];
   logic          drop_o [2];
   logic [CW-1:0] cnt_o  [2];

   int total = 0;
   int bad   = 0;

   // Beat-level model, index 0 = ARB_MIN, 1 = ARB_MAX.
   bit            m_full [2];
   int            m_idx  [2];
   logic [DW-1:0] m_data [2];
   bit            m_drop [2];
   int            m_cnt  [2];
   int            sq0[$];
   int            sq1[$];
   bit            p_stall [2];
   logic [N-1:0]  p_vld   [2];
   logic [DW-1:0] p_data  [2];

   always #5 clk = ~clk;

   cm_dispatch #(
      .N_SINK (N),
      .DATA_W (DW),
      .ALGO   (ARB_MIN),
      .CNT_W  (CW)
   ) u_min (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_vld      (vld),
      .o_rdy      (rdy_o[0]),
      .i_data     (data),
      .i_mask     (mask),
      .o_vld      (vld_o[0]),
      .i_rdy      (rdy),
      .o_data     (data_o[0]),
      .o_drop     (drop_o[0]),
      .o_drop_cnt (cnt_o[0])
   );

   cm_dispatch #(
      .N_SINK (N),
      .DATA_W (DW),
      .ALGO   (ARB_MAX),
      .CNT_W  (CW)
   ) u_max (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_vld      (vld),
      .o_rdy      (rdy_o[1]),
      .i_data     (data),
      .i_mask     (mask),
      .o_vld      (vld_o[1]),
      .i_rdy      (rdy),
      .o_data     (data_o[1]),
      .o_drop     (drop_o[1]),
      .o_drop_cnt (cnt_o[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Lowest (a=0) or highest (a=1) set bit of m; -1 if none.
   function automatic int pick(input logic [N-1:0] m, input int a);
      int r = -1;
      for (int i = 0; i < N; i++) begin
         if (m[i] && (a == 1 || r < 0)) r = i;
      end
      return r;
   endfunction

   function automatic int idx_of(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic mreset();
      for (int a = 0; a < 2; a++) begin
         m_full[a]  = 1'b0;
         m_idx[a]   = 0;
         m_data[a]  = '0;
         m_drop[a]  = 1'b0;
         m_cnt[a]   = 0;
         p_stall[a] = 1'b0;
         p_vld[a]   = '0;
         p_data[a]  = '0;
      end
      sq0.delete();
      sq1.delete();
   endtask

   // Called just after a rising edge: drive inputs, check mid-cycle, advance model at the edge.
   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [N-1:0] m,
                      input logic [N-1:0] r);
      logic [N-1:0] ev;
      bit           erdy [2];
      int           e;
      int           act;
      vld  = v;
      data = d;
      mask = m;
      rdy  = r;
      #3;
      for (int a = 0; a < 2; a++) begin
         ev      = m_full[a] ? N'(1 << m_idx[a]) : '0;
         erdy[a] = !m_full[a] || r[m_idx[a]];
         chk($sformatf("o_vld[%0d]", a), int'(vld_o[a]), int'(ev));
         chk($sformatf("o_rdy[%0d]", a), int'(rdy_o[a]), int'(erdy[a]));
         chk($sformatf("o_data[%0d]", a), int'(data_o[a]), int'(m_data[a]));
         chk($sformatf("o_drop[%0d]", a), int'(drop_o[a]), int'(m_drop[a]));
         chk($sformatf("o_drop_cnt[%0d]", a), int'(cnt_o[a]), m_cnt[a]);
         chk($sformatf("onehot[%0d]", a), int'($countones(vld_o[a]) <= 1), 1);
         if (p_stall[a]) begin
            chk($sformatf("stall_vld[%0d]", a), int'(vld_o[a]), int'(p_vld[a]));
            chk($sformatf("stall_data[%0d]", a), int'(data_o[a]), int'(p_data[a]));
         end
         p_stall[a] = (vld_o[a] != '0) && ((vld_o[a] & r) == '0);
         p_vld[a]   = vld_o[a];
         p_data[a]  = data_o[a];
         // In-order delivery scoreboard.
         if ((vld_o[a] & r) != '0) begin
            act = idx_of(vld_o[a]) * 256 + int'(data_o[a]);
            if (a == 0) e = (sq0.size() > 0) ? sq0.pop_front() : -1;
            else        e = (sq1.size() > 0) ? sq1.pop_front() : -1;
            chk($sformatf("delivery[%0d]", a), act, e);
         end
      end
      @(posedge clk);
      for (int a = 0; a < 2; a++) begin
         bit drain;
         bit acc;
         drain     = m_full[a] && r[m_idx[a]];
         acc       = v && erdy[a];
         m_drop[a] = acc && (m == '0);
         if (acc && m != '0) begin
            m_full[a] = 1'b1;
            m_idx[a]  = pick(m, a);
            m_data[a] = d;
            if (a == 0) sq0.push_back(m_idx[a] * 256 + int'(d));
            else        sq1.push_back(m_idx[a] * 256 + int'(d));
         end else begin
            if (drain) m_full[a] = 1'b0;
            if (acc && m_cnt[a] < 255) m_cnt[a]++;
         end
      end
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      vld  = 1'b0;
      data = '0;
      mask = '0;
      rdy  = '0;
      mreset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      // Reset values
      for (int a = 0; a < 2; a++) begin
         chk("reset_vld", int'(vld_o[a]), 0);
         chk("reset_rdy", int'(rdy_o[a]), 1);
         chk("reset_data", int'(data_o[a]), 0);
         chk("reset_cnt", int'(cnt_o[a]), 0);
      end

      // Policy: mask 0110 -> sink 1 (MIN), sink 2 (MAX)
      cyc(1'b1, 8'hA5, 4'b0110, 4'b1111);
      chk("policy_min", int'(vld_o[0]), 4'b0010);
      chk("policy_max", int'(vld_o[1]), 4'b0100);
      chk("policy_data", int'(data_o[0]), 8'hA5);
      cyc(1'b0, 8'h00, 4'b0000, 4'b1111);
      chk("policy_drained", int'(vld_o[0] | vld_o[1]), 0);

      // Backpressure on sink 1
      cyc(1'b1, 8'h11, 4'b0010, 4'b1101);
      for (int k = 0; k < 5; k++) begin
         chk("bp_vld", int'(vld_o[0]), 4'b0010);
         chk("bp_data", int'(data_o[0]), 8'h11);
         chk("bp_rdy", int'(rdy_o[0]), 0);
         cyc(1'b0, 8'h00, 4'b0000, 4'b1101);
      end
      rdy = 4'b1111;
      #1;
      chk("bp_release_rdy", int'(rdy_o[0]), 1);
      cyc(1'b0, 8'h00, 4'b0000, 4'b1111);
      chk("bp_drained", int'(vld_o[0]), 0);

      // Back-to-back, no bubble
      cyc(1'b1, 8'h01, 4'b0001, 4'b1111);
      chk("b2b_0", int'(vld_o[0]), 4'b0001);
      cyc(1'b1, 8'h02, 4'b1000, 4'b1111);
      chk("b2b_1", int'(vld_o[0]), 4'b1000);
      chk("b2b_1_data", int'(data_o[0]), 8'h02);
      cyc(1'b1, 8'h03, 4'b0100, 4'b1111);
      chk("b2b_2", int'(vld_o[0]), 4'b0100);
      cyc(1'b0, 8'h00, 4'b0000, 4'b1111);
      chk("b2b_end", int'(vld_o[0]), 0);

      // Drops and saturation
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 8'hEE, 4'b0000, 4'b1111);
         chk("drop_pulse", int'(drop_o[0]), 1);
         chk("drop_novld", int'(vld_o[0]), 0);
      end
      chk("drop_cnt3", int'(cnt_o[0]), 3);
      cyc(1'b0, 8'h00, 4'b0000, 4'b1111);
      chk("drop_idle", int'(drop_o[0]), 0);
      for (int k = 0; k < 260; k++) cyc(1'b1, 8'h00, 4'b0000, 4'b1111);
      chk("drop_sat", int'(cnt_o[0]), 255);
      chk("drop_sat_max", int'(cnt_o[1]), 255);

      // Asynchronous reset while FULL
      cyc(1'b1, 8'h77, 4'b1000, 4'b0000);
      cyc(1'b0, 8'h00, 4'b0000, 4'b0000);
      chk("pre_rst_vld", int'(vld_o[0]), 4'b1000);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_vld", int'(vld_o[0] | vld_o[1]), 0);
      chk("async_rst_rdy", int'(rdy_o[0] & rdy_o[1]), 1);
      chk("async_rst_cnt", int'(cnt_o[0] | cnt_o[1]), 0);
      mreset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Random run
      for (int k = 0; k < 10000; k++) begin
         cyc(($urandom_range(3) != 0), 8'($urandom), 4'($urandom), 4'($urandom));
      end
      cyc(1'b0, 8'h00, 4'b0000, 4'b1111);
      cyc(1'b0, 8'h00, 4'b0000, 4'b1111);
      chk("sb_empty_min", sq0.size(), 0);
      chk("sb_empty_max", sq1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
